alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 33 +++
 rtl/alu_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encodings and opcode-validity decode
// for alu_ctrl and its ALU datapath.
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  typedef logic [2:0] state_t;

  localparam state_t S_A    = 3'd0;
  localparam state_t S_B    = 3'd1;
  localparam state_t S_OP   = 3'd2;
  localparam state_t S_EXEC = 3'd3;
  localparam state_t S_SEND = 3'd4;

  function automatic logic op_is_valid(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_is_valid = 1'b1;
      default:                        op_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: modulo-2^NB_DATA arithmetic/logic/shift on A and B.
// Shifts move A by B bit positions; unsupported opcodes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  logic [OP_W-1:0] op;
  assign op = OP_W'(i_op);

  always_comb begin
    o_result = '0;
    case (op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_SRA: o_result = NB_DATA'($signed(i_a) >>> i_b);
      OP_SRL: o_result = i_a >> i_b;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Byte-serial ALU controller: collects A, B, opcode, executes, holds result
// until accepted. Define ALU_CTRL_OPCHECK_EN to reject unsupported opcodes.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_error,
  output logic [7:0]         o_drop_cnt
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [NB_DATA-1:0] alu_result;

`ifdef ALU_CTRL_OPCHECK_EN
  logic error_q, error_d;
  logic op_byte_ok;

  // Whole byte must decode: any set bit above the opcode field is a reject.
  assign op_byte_ok = op_is_valid(OP_W'(i_rx_data[NB_OP-1:0])) &&
                      ((i_rx_data >> NB_OP) == '0);
`endif

  alu #(
    .NB_DATA(NB_DATA),
    .NB_OP  (NB_OP)
  ) u_alu (
    .i_a     (a_q),
    .i_b     (b_q),
    .i_op    (op_q),
    .o_result(alu_result)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    drop_cnt_d = drop_cnt_q;
`ifdef ALU_CTRL_OPCHECK_EN
    error_d    = error_q;
`endif

    if (i_rx_valid && (state_q == S_EXEC || state_q == S_SEND) && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 8'd1;

    case (state_q)
      S_A: if (i_rx_valid) begin
        a_d     = i_rx_data;
        state_d = S_B;
`ifdef ALU_CTRL_OPCHECK_EN
        error_d = 1'b0;
`endif
      end
      S_B: if (i_rx_valid) begin
        b_d     = i_rx_data;
        state_d = S_OP;
      end
      S_OP: if (i_rx_valid) begin
        op_d = i_rx_data[NB_OP-1:0];
`ifdef ALU_CTRL_OPCHECK_EN
        if (op_byte_ok) begin
          state_d = S_EXEC;
        end else begin
          error_d = 1'b1;
          state_d = S_A;
        end
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        tx_data_d  = alu_result;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: if (i_tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = S_A;
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef ALU_CTRL_OPCHECK_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef ALU_CTRL_OPCHECK_EN
      error_q    <= error_d;
`endif
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = (state_q == S_EXEC) || (state_q == S_SEND);
  assign o_drop_cnt = drop_cnt_q;
`ifdef ALU_CTRL_OPCHECK_EN
  assign o_error    = error_q;
`else
  assign o_error    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal results.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       error;
  logic [7:0] drop_cnt;

  int cmps = 0;
  int errs = 0;

  alu_ctrl #(
    .NB_DATA(8),
    .NB_OP  (6)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_rx_data (rx_data),
    .i_rx_valid(rx_valid),
    .o_tx_data (tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_busy    (busy),
    .o_error   (error),
    .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

`ifdef ALU_CTRL_OPCHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from the opcode table, using plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
    int v;
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (op[5:0])
      6'h20: return 8'((ia + ib) % 256);
      6'h22: return 8'((ia - ib + 256) % 256);
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return 8'(255 - (ia | ib));
      6'h03: begin
        v = (ia >= 128) ? ia - 256 : ia;
        if (ib >= 8) return (ia >= 128) ? 8'hFF : 8'h00;
        return 8'(v / (1 << ib) - (((v < 0) && (v % (1 << ib) != 0)) ? 1 : 0));
      end
      6'h02: return (ib >= 8) ? 8'h00 : 8'(ia / (1 << ib));
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_listed(input logic [7:0] op);
    logic [7:0] legal [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction model: bytes collected so far, and where a result is in its life
  // (0 none, 1 computing, 2 offered to the consumer).
  int         m_nbytes;
  logic [7:0] m_a, m_b, m_op;
  int         m_pend;
  logic [7:0] m_data;
  bit         m_err;
  int         m_drops;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_nbytes = 0; m_a = 0; m_b = 0; m_op = 0;
      m_pend = 0; m_data = 0; m_err = 0; m_drops = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_pend != 0 && rx_valid && m_drops < 255) m_drops++;
      if (m_pend == 1) begin
        m_data = ref_alu(m_a, m_b, m_op);
        m_pend = 2;
      end else if (m_pend == 2) begin
        if (tx_ready) m_pend = 0;
      end else if (rx_valid) begin
        if (m_nbytes == 0) begin
          m_a = rx_data; m_err = 0; m_nbytes = 1;
        end else if (m_nbytes == 1) begin
          m_b = rx_data; m_nbytes = 2;
        end else begin
          m_op = rx_data; m_nbytes = 0;
          if (CHECK_EN && !op_listed(rx_data)) m_err = 1;
          else m_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_tx_valid", 32'(tx_valid), 32'(m_pend == 2));
      check("model_busy", 32'(busy), 32'(m_pend != 0));
      check("model_tx_data", 32'(tx_data), 32'(m_data));
      check("model_error", 32'(error), 32'(m_err));
      check("model_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10] = '{
    '{8'hF0, 8'h0F, 8'h27, 8'h00},
    '{8'h3C, 8'h0F, 8'h24, 8'h0C},
    '{8'h3C, 8'h0F, 8'h25, 8'h3F},
    '{8'h3C, 8'h0F, 8'h26, 8'h33},
    '{8'h80, 8'h02, 8'h03, 8'hE0},
    '{8'h80, 8'h02, 8'h02, 8'h20},
    '{8'h7F, 8'h01, 8'h03, 8'h3F},
    '{8'h12, 8'h34, 8'h20, 8'h46},
    '{8'hFF, 8'h01, 8'h20, 8'h00},
    '{8'h81, 8'h09, 8'h03, 8'hFF}
  };

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    tick(2);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_error", 32'(error), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    rst = 1'b0;
    tick(1);

    // add with zero-wait consumer, latency pinned cycle by cycle
    send(8'h05); send(8'h03); send(8'h20);
    check("add_exec_busy", 32'(busy), 1);
    check("add_exec_valid", 32'(tx_valid), 0);
    tick(1);
    check("add_valid", 32'(tx_valid), 1);
    check("add_data", 32'(tx_data), 32'h08);
    tick(1);
    check("add_done_valid", 32'(tx_valid), 0);
    check("add_done_busy", 32'(busy), 0);

    // sub wrap with idle gaps between bytes
    send(8'h00); tick(3); send(8'h01); tick(2); send(8'h22);
    tick(1);
    check("sub_wrap", 32'(tx_data), 32'hFF);
    tick(1);

    foreach (vecs[i]) begin
      send(vecs[i].a); send(vecs[i].b); send(vecs[i].op);
      tick(1);
      check($sformatf("vec%0d_valid", i), 32'(tx_valid), 1);
      check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp));
      tick(1);
    end

    // consumer stalls 5 cycles, accepts on the 6th
    tx_ready = 1'b0;
    send(8'h09); send(8'h04); send(8'h22);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(tx_valid), 1);
      check($sformatf("stall%0d_data", i), 32'(tx_data), 32'h05);
      tick(1);
    end
    tx_ready = 1'b1;
    check("stall_last_valid", 32'(tx_valid), 1);
    tick(1);
    check("stall_accept_valid", 32'(tx_valid), 0);
    check("stall_accept_busy", 32'(busy), 0);

    // strobes while a result is pending are dropped and counted
    tx_ready = 1'b0;
    send(8'h10); send(8'h20); send(8'h20);
    tick(1);
    send(8'hAA); send(8'hBB); send(8'hCC);
    check("drop3", 32'(drop_cnt), 3);
    check("drop3_data", 32'(tx_data), 32'h30);
    tx_ready = 1'b1;
    tick(1);
    send(8'h06); send(8'h07); send(8'h20);
    tick(1);
    check("after_drop_data", 32'(tx_data), 32'h0D);
    tick(1);

    // unsupported opcodes
    send(8'h01); send(8'h02); send(8'h3F);
`ifdef ALU_CTRL_OPCHECK_EN
    check("bad3f_error", 32'(error), 1);
    check("bad3f_busy", 32'(busy), 0);
    tick(2);
    check("bad3f_no_valid", 32'(tx_valid), 0);
    check("bad3f_sticky", 32'(error), 1);
    send(8'h04);
    check("bad3f_clear", 32'(error), 0);
    send(8'h05); send(8'hA0);
    check("badhi_error", 32'(error), 1);
    tick(1);
    check("badhi_no_valid", 32'(tx_valid), 0);
`else
    check("op3f_error", 32'(error), 0);
    tick(1);
    check("op3f_valid", 32'(tx_valid), 1);
    check("op3f_data", 32'(tx_data), 0);
    tick(1);
    send(8'h04); send(8'h05); send(8'hA0);
    tick(1);
    check("opa0_data", 32'(tx_data), 32'h09);
    tick(1);
`endif

    // drop counter saturation (3 already counted)
    tx_ready = 1'b0;
    send(8'h01); send(8'h01); send(8'h20);
    tick(1);
    repeat (260) send(8'h00);
    check("drop_sat", 32'(drop_cnt), 32'hFF);
    tx_ready = 1'b1;
    tick(1);

    // reset mid-sequence, then a full transaction
    send(8'h11); send(8'h22);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_valid", 32'(tx_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    check("mid_rst_error", 32'(error), 0);
    send(8'h00); send(8'h01); send(8'h22);
    tick(1);
    check("post_rst_data", 32'(tx_data), 32'hFF);
    check("post_rst_valid", 32'(tx_valid), 1);
    tick(2);

    // reset while a result is offered
    tx_ready = 1'b0;
    send(8'h02); send(8'h02); send(8'h20);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("send_rst_valid", 32'(tx_valid), 0);
    check("send_rst_data", 32'(tx_data), 0);
    tx_ready = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
